// File: rtl/logic_pipe_if.sv
// logic_pipe_if
//   Handshake bundle between an operand source, the logic_pipe unit and a
//   result consumer.
//   Operand side : in_valid, in_ready, a, b, op
//   Result side  : out_valid, out_ready, out, zr, ng
//   master : the source/consumer side (drives operands, accepts results)
//   slave  : the logic_pipe unit itself
interface logic_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/logic_pipe.sv
// logic_pipe
//   Pipelined WIDTH-bit bitwise logic unit with Hack-style zr/ng flags.
//   The result of (a op b) is computed at the input, tagged with its flags and
//   carried through STAGES valid/ready register stages. Empty stages collapse,
//   so up to STAGES results can be held while the consumer stalls.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset (clears all stages and outputs)
//     bus   : logic_pipe_if slave modport
//             in_valid/in_ready/a/b/op  operand transfer
//             out_valid/out_ready/out/zr/ng  result transfer
//   op: 000 and, 001 or, 010 xor, 011 nand, 100 nor, 101 xnor, 110 not a, 111 a
module logic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    logic_pipe_if.slave bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("logic_pipe: WIDTH must be >= 1");
    end

    if (STAGES < 1) begin : g_bad_stages
        $error("logic_pipe: STAGES must be >= 1");
    end

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [2:0]       sel
    );
        logic [WIDTH-1:0] r;
        r = x;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            3'b111:  r = x;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic zero_flag(input logic [WIDTH-1:0] x);
        return (x == {WIDTH{1'b0}});
    endfunction

    function automatic logic sign_flag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1];
    endfunction

    logic [WIDTH-1:0]  result_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] zr_r;
    logic [STAGES-1:0] ng_r;
    logic [WIDTH-1:0]  data_r [STAGES];

    // Combinational result of the offered operands.
    always_comb begin
        result_s = apply_op(bus.a, bus.b, bus.op);
    end

    // Backward ready chain: a stage advances when its successor loads, and
    // loads when it is empty or advancing. Built from the output end inward.
    always_comb begin
        adv_s  = {STAGES{1'b0}};
        load_s = {STAGES{1'b0}};
        adv_s[STAGES-1]  = valid_r[STAGES-1] & bus.out_ready;
        load_s[STAGES-1] = ~valid_r[STAGES-1] | adv_s[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv_s[i]  = valid_r[i] & load_s[i+1];
            load_s[i] = ~valid_r[i] | adv_s[i];
        end
    end

    // Stage registers. An invalid entry always carries zero data and flags,
    // so nothing undefined on a/b/op can reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {STAGES{1'b0}};
            zr_r    <= {STAGES{1'b0}};
            ng_r    <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (load_s[0]) begin
                valid_r[0] <= bus.in_valid;
                data_r[0]  <= bus.in_valid ? result_s : {WIDTH{1'b0}};
                zr_r[0]    <= bus.in_valid & zero_flag(result_s);
                ng_r[0]    <= bus.in_valid & sign_flag(result_s);
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load_s[i]) begin
                    valid_r[i] <= valid_r[i-1];
                    data_r[i]  <= data_r[i-1];
                    zr_r[i]    <= zr_r[i-1];
                    ng_r[i]    <= ng_r[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = load_s[0];
    assign bus.out_valid = valid_r[STAGES-1];
    assign bus.out       = data_r[STAGES-1];
    assign bus.zr        = zr_r[STAGES-1];
    assign bus.ng        = ng_r[STAGES-1];

endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe
//   dut_a: WIDTH=16, STAGES=2 for the vector table and directed sequences.
//   dut_b: WIDTH=8,  STAGES=3 for the randomized soak against a truth-table
//   reference model and an expected-result queue.
module tb_logic_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic_pipe_if #(.WIDTH(16)) bus_a ();
    logic_pipe_if #(.WIDTH(8))  bus_b ();

    logic_pipe #(.WIDTH(16), .STAGES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    logic_pipe #(.WIDTH(8),  .STAGES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } vec_t;

    localparam int NV = 12;
    localparam int LAT_A = 2;
    localparam int DEPTH_B = 3;
    vec_t tbl [NV];

    // Per-op truth tables, 4 bits each, indexed by {a_bit, b_bit}; op 0 lowest.
    localparam logic [31:0] TT = {4'b1100, 4'b0011, 4'b1001, 4'b0001,
                                  4'b0111, 4'b0110, 4'b1110, 4'b1000};

    logic [9:0]  sq [$];
    logic        hold_pending = 1'b0;
    logic [10:0] held = 11'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] sel);
        logic [31:0] tt_all;
        logic [3:0]  tt;
        logic [7:0]  r;
        tt_all = TT;
        tt = tt_all[sel*4 +: 4];
        for (int i = 0; i < 8; i++) begin
            r[i] = tt[{x[i], y[i]}];
        end
        return r;
    endfunction

    task automatic set_a(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [2:0] sel);
        bus_a.in_valid = v;
        bus_a.a = x;
        bus_a.b = y;
        bus_a.op = sel;
    endtask

    task automatic soak_step(input bit drain);
        logic [7:0] r;
        @(negedge clk);
        if (drain) begin
            bus_b.in_valid  = 1'b0;
            bus_b.out_ready = 1'b1;
        end else begin
            bus_b.in_valid  = ($urandom_range(0, 99) < 70);
            bus_b.out_ready = ($urandom_range(0, 99) < 60);
            bus_b.a  = 8'($urandom);
            bus_b.b  = 8'($urandom);
            bus_b.op = 3'($urandom);
        end
        #1;
        if (hold_pending) begin
            check("soak hold", {bus_b.out_valid, bus_b.out, bus_b.zr, bus_b.ng}, held);
        end
        check("soak in_ready", bus_b.in_ready, (sq.size() < DEPTH_B) || bus_b.out_ready);
        if (bus_b.out_valid && bus_b.out_ready) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL soak extra result: got %0h expected none", bus_b.out);
            end else begin
                check("soak result", {bus_b.out, bus_b.zr, bus_b.ng}, sq.pop_front());
            end
        end
        if (bus_b.in_valid && bus_b.in_ready) begin
            r = ref_op(bus_b.a, bus_b.b, bus_b.op);
            sq.push_back({r, r == 8'h00, r[7]});
        end
        hold_pending = bus_b.out_valid && !bus_b.out_ready;
        held = {bus_b.out_valid, bus_b.out, bus_b.zr, bus_b.ng};
    endtask

    initial begin
        logic exp_v;

        tbl[0]  = '{16'hF0F0, 16'hFF00, 3'd0, 16'hF000, 1'b0, 1'b1};
        tbl[1]  = '{16'hF0F0, 16'hFF00, 3'd1, 16'hFFF0, 1'b0, 1'b1};
        tbl[2]  = '{16'hF0F0, 16'hFF00, 3'd2, 16'h0FF0, 1'b0, 1'b0};
        tbl[3]  = '{16'hF0F0, 16'hFF00, 3'd3, 16'h0FFF, 1'b0, 1'b0};
        tbl[4]  = '{16'hF0F0, 16'hFF00, 3'd4, 16'h000F, 1'b0, 1'b0};
        tbl[5]  = '{16'hF0F0, 16'hFF00, 3'd5, 16'hF00F, 1'b0, 1'b1};
        tbl[6]  = '{16'hF0F0, 16'hFF00, 3'd6, 16'h0F0F, 1'b0, 1'b0};
        tbl[7]  = '{16'hF0F0, 16'hFF00, 3'd7, 16'hF0F0, 1'b0, 1'b1};
        tbl[8]  = '{16'h0000, 16'hFFFF, 3'd0, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{16'h1234, 16'h1234, 3'd5, 16'hFFFF, 1'b0, 1'b1};
        tbl[10] = '{16'hFFFF, 16'h1234, 3'd6, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{16'h8000, 16'h0000, 3'd2, 16'h8000, 1'b0, 1'b1};

        set_a(1'b0, 16'h0000, 16'h0000, 3'd0);
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.a = 8'h00;
        bus_b.b = 8'h00;
        bus_b.op = 3'd0;
        bus_b.out_ready = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", bus_a.out_valid, 1'b0);
        check("reset out", bus_a.out, 16'h0000);
        check("reset zr", bus_a.zr, 1'b0);
        check("reset ng", bus_a.ng, 1'b0);
        check("reset in_ready", bus_a.in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table sweep: entry n shows at the negedge n+LAT_A.
        for (int n = 0; n <= NV + LAT_A; n++) begin
            exp_v = (n >= LAT_A) && (n - LAT_A < NV);
            check("sweep out_valid", bus_a.out_valid, exp_v);
            if (exp_v) begin
                check("sweep out", bus_a.out, tbl[n-LAT_A].out);
                check("sweep zr", bus_a.zr, tbl[n-LAT_A].zr);
                check("sweep ng", bus_a.ng, tbl[n-LAT_A].ng);
            end
            if (n < NV) begin
                check("sweep in_ready", bus_a.in_ready, 1'b1);
                set_a(1'b1, tbl[n].a, tbl[n].b, tbl[n].op);
            end else begin
                set_a(1'b0, 16'h0000, 16'h0000, 3'd0);
            end
            @(negedge clk);
        end

        // Backpressure: two accepted, then full and held.
        bus_a.out_ready = 1'b0;
        set_a(1'b1, 16'h0001, 16'hFFFF, 3'd0);
        #1 check("bp in_ready 1", bus_a.in_ready, 1'b1);
        @(negedge clk);
        set_a(1'b1, 16'h0002, 16'hFFFF, 3'd0);
        #1 check("bp in_ready 2", bus_a.in_ready, 1'b1);
        check("bp out_valid early", bus_a.out_valid, 1'b0);
        @(negedge clk);
        set_a(1'b1, 16'h0003, 16'hFFFF, 3'd0);
        #1 check("bp full in_ready", bus_a.in_ready, 1'b0);
        check("bp out_valid", bus_a.out_valid, 1'b1);
        check("bp out first", bus_a.out, 16'h0001);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus_a.a = 16'h0003 + 16'(k);  // item 3 not yet taken; value irrelevant while full
            #1 check("bp hold in_ready", bus_a.in_ready, 1'b0);
            check("bp hold out", {bus_a.out_valid, bus_a.out, bus_a.zr, bus_a.ng}, {1'b1, 16'h0001, 1'b0, 1'b0});
        end
        bus_a.a = 16'h0003;
        bus_a.out_ready = 1'b1;
        #1 check("bp release in_ready", bus_a.in_ready, 1'b1);
        @(negedge clk);
        set_a(1'b1, 16'h0004, 16'hFFFF, 3'd0);
        #1 check("bp out 2", {bus_a.out_valid, bus_a.out}, {1'b1, 16'h0002});
        check("bp in_ready 4", bus_a.in_ready, 1'b1);
        @(negedge clk);
        set_a(1'b0, 16'h0000, 16'h0000, 3'd0);
        #1 check("bp out 3", {bus_a.out_valid, bus_a.out}, {1'b1, 16'h0003});
        @(negedge clk);
        #1 check("bp out 4", {bus_a.out_valid, bus_a.out}, {1'b1, 16'h0004});
        @(negedge clk);
        #1 check("bp drained", bus_a.out_valid, 1'b0);

        // Reset with two transactions in flight.
        bus_a.out_ready = 1'b0;
        set_a(1'b1, 16'h00AA, 16'hFFFF, 3'd0);
        @(negedge clk);
        set_a(1'b1, 16'h00BB, 16'hFFFF, 3'd0);
        @(negedge clk);
        set_a(1'b0, 16'h0000, 16'h0000, 3'd0);
        #1 check("mid full out_valid", {bus_a.out_valid, bus_a.out}, {1'b1, 16'h00AA});
        #1 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", bus_a.out_valid, 1'b0);
        check("mid reset out", {bus_a.out, bus_a.zr, bus_a.ng}, 18'h0);
        check("mid reset in_ready", bus_a.in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        set_a(1'b1, 16'h00FF, 16'h0F0F, 3'd2);
        @(negedge clk);
        set_a(1'b0, 16'h0000, 16'h0000, 3'd0);
        #1 check("post reset no stale", bus_a.out_valid, 1'b0);
        @(negedge clk);
        #1 check("post reset result", {bus_a.out_valid, bus_a.out, bus_a.zr, bus_a.ng}, {1'b1, 16'h0FF0, 1'b0, 1'b0});
        @(negedge clk);
        #1 check("post reset single", bus_a.out_valid, 1'b0);

        // Random soak on the 8-bit, 3-stage instance, then drain.
        for (int c = 0; c < 10000; c++) begin
            soak_step(1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            soak_step(1'b1);
        end
        check("soak leftover", sq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_pipe.md
Name: logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the single-bit combinational And gate.
- Generalises to WIDTH-bit words and eight selectable logic ops, computed per transaction.
- Results carry Hack-style zr/ng flags and travel through STAGES register stages with valid/ready handshakes at both ends.
- Sits between the operand source (CPU datapath or test harness) and a consumer that may stall.

Parameters:
- WIDTH, 16, operand/result width in bits (Hack word); must be >= 1.
- STAGES, 2, number of pipeline register stages = minimum latency in cycles; must be >= 1, else elaboration error.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  pipeline can accept; transfer when in_valid && in_ready at a rising edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select, sampled with the transfer.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at a rising edge.
- out  output  WIDTH  result.
- zr  output  1  1 when out == 0.
- ng  output  1  out[WIDTH-1].

Behaviour:
- Op encoding:
  - 000 a&b; 001 a|b; 010 a^b; 011 ~(a&b); 100 ~(a|b); 101 ~(a^b); 110 ~a; 111 a (pass).
  - Op is applied bitwise across all WIDTH bits. b is ignored for 110/111.
- Datapath:
  - Result is computed combinationally from a, b and op at the input.
  - It is written into stage 0 together with zr/ng computed from that result.
  - Stage STAGES-1 drives out, zr, ng and out_valid.
- Stage state: each stage holds valid plus data.
  - Stage i loads from stage i-1 (or from the input for i=0) when stage i is empty or advancing.
  - The last stage advances when out_ready is high.
  - Stage i < STAGES-1 advances when it is valid and stage i+1 is loading.
  - in_ready = !stage0.valid || stage0 advancing. in_ready is combinational from out_ready through the valid chain.
- Latency and throughput:
  - Without stalls, a result appears on out_valid exactly STAGES cycles after the input transfer edge.
  - Sustained throughput is 1 transaction/cycle.
- Bubbles: empty stages collapse, so the pipeline holds up to STAGES transactions under backpressure.
- Ordering: strict FIFO order, with no drop and no duplication.
- Output stability: while out_valid && !out_ready, out, zr and ng hold their values.
- Full: all STAGES valid and out_ready=0 → in_ready=0. in_valid is ignored and a/b/op may change freely.
- Simultaneous events: full pipeline with out_ready=1 → in_ready=1 in the same cycle; one result leaves and one operand enters on the same edge.
- Reset:
  - rst_n low forces all stage valids to 0 and data/out/zr/ng to 0 immediately, without waiting for clk.
  - in_ready=1 while in reset.
  - In-flight transactions are discarded.
  - First transfer is accepted on the first rising edge after rst_n deasserts.
- No X propagation: outputs are defined from reset onward, regardless of a/b/op values while invalid.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → out_valid=0, out=0, zr=0, ng=0, in_ready=1 before the next clk edge. Hold 2 cycles, release.
- Op sweep: a=16'hF0F0, b=16'hFF00, op=0..7 back-to-back, out_ready=1. Expect each result exactly STAGES=2 cycles later, in order, out_valid high 8 consecutive cycles:
  - F000, FFF0, 0FF0, 0FFF, 000F, F00F, 0F0F, F0F0.
  - ng = 1,1,0,0,0,1,0,1.
- Flags:
  - a=16'h0000, b=16'hFFFF, op=000 → out=0000, zr=1, ng=0.
  - op=101 with a=b=16'h1234 → out=FFFF, zr=0, ng=1.
- Backpressure: out_ready=0, offer 4 transactions (AND, a=i, b=16'hFFFF, i=1..4).
  - Expect items 1,2 accepted, in_ready=0 after the 2nd, out=0001 held stable.
  - Then out_ready=1 → outputs 0001,0002,0003,0004 in order, in_ready high in the same cycle the first pops.
- Random soak: WIDTH=8, STAGES=3, random in_valid/out_ready/a/b/op over 10k cycles. Reference-model scoreboard shows zero mismatches, no loss or duplication.
- Reset mid-flight: two transactions in pipeline, pulse rst_n low → out_valid=0 at once. After release no stale result appears, and a new transfer yields its correct result after STAGES cycles.
